// File: rtl/wb_decoder_n.sv
// Wishbone 1-master / NSLV-slave address decoder with registered select,
// unmapped-address error, per-transaction timeout and error status/IRQ.
module wb_decoder_n #(
  parameter int NSLV = 7,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NSLV*ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [NSLV*ADDR_W-1:0] MASK_ADDR = {NSLV{ADDR_W'(32'hFFF)}},
  parameter int TIMEOUT_CYC = 256,
  parameter logic [15:0] ERR_CNT_INIT = 16'h0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   m_cyc_i,
  input  logic                   m_stb_i,
  input  logic                   m_we_i,
  input  logic [ADDR_W-1:0]      m_adr_i,
  input  logic [DATA_W-1:0]      m_dat_i,
  input  logic [DATA_W/8-1:0]    m_sel_i,
  output logic [DATA_W-1:0]      m_dat_o,
  output logic                   m_ack_o,
  output logic                   m_err_o,
  output logic [NSLV-1:0]        s_cyc_o,
  output logic [NSLV-1:0]        s_stb_o,
  output logic                   s_we_o,
  output logic [ADDR_W-1:0]      s_adr_o,
  output logic [DATA_W-1:0]      s_dat_o,
  output logic [DATA_W/8-1:0]    s_sel_o,
  input  logic [NSLV*DATA_W-1:0] s_dat_i,
  input  logic [NSLV-1:0]        s_ack_i,
  input  logic [NSLV-1:0]        s_err_i,
  output logic                   err_irq_o,
  output logic [15:0]            err_cnt_o,
  output logic [ADDR_W-1:0]      err_adr_o
);

  localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic               irq_q;
  logic [15:0]        err_cnt_q;
  logic [ADDR_W-1:0]  err_adr_q;

  logic               hit;
  logic [SEL_W-1:0]   hit_idx;
  logic               ack_sel, err_sel, tmo, err_evt;

  // Scan downward so the lowest matching slave wins on overlap.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if ((m_adr_i & ~MASK_ADDR[k*ADDR_W +: ADDR_W])
          == BASE_ADDR[k*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  assign ack_sel = s_ack_i[sel_q];
  assign err_sel = s_err_i[sel_q];
  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) && !ack_sel && !err_sel;

  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    cnt_d = '0;
    adr_d = adr_q;
    err_evt = 1'b0;
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    m_dat_o = '0;
    s_cyc_o = '0;
    s_stb_o = '0;
    s_we_o = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    unique case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          adr_d = m_adr_i;
          if (hit) begin
            state_d = BUSY;
            sel_d = hit_idx;
          end else begin
            state_d = ERR;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        s_we_o = m_we_i;
        s_adr_o = m_adr_i;
        s_dat_o = m_dat_i;
        s_sel_o = m_sel_i;
        if (m_cyc_i && !tmo) begin
          s_cyc_o[sel_q] = 1'b1;
          s_stb_o[sel_q] = m_stb_i;
        end
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else if (err_sel || tmo) begin
          m_err_o = 1'b1;
          err_evt = 1'b1;
          state_d = IDLE;
        end else if (ack_sel) begin
          m_ack_o = 1'b1;
          m_dat_o = s_dat_i[sel_q*DATA_W +: DATA_W];
          state_d = IDLE;
        end
      end
      ERR: begin
        m_err_o = 1'b1;
        err_evt = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q <= '0;
      cnt_q <= '0;
      adr_q <= '0;
      irq_q <= 1'b0;
      err_cnt_q <= ERR_CNT_INIT;
      err_adr_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      adr_q <= adr_d;
      irq_q <= err_evt;
      if (err_evt) begin
        err_adr_q <= adr_q;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign err_irq_o = irq_q;
  assign err_cnt_o = err_cnt_q;
  assign err_adr_o = err_adr_q;

endmodule

// File: tb/tb_wb_decoder_n.sv
// Directed bench for wb_decoder_n: decode, unmapped error, timeout,
// overlap priority, abort, reset and error-counter saturation.
module tb_wb_decoder_n;

  localparam int N = 4;
  localparam logic [N*32-1:0] BASE =
    {32'h0300_0000, 32'h0100_0000, 32'h0200_1000, 32'h0100_0000};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0] sel;
  logic [N*32-1:0] sdat;
  logic [N-1:0] sack, serr;

  logic [31:0] m_dat, s_adr, s_dat, e_adr;
  logic m_ack, m_err, s_we, irq;
  logic [N-1:0] s_cyc, s_stb;
  logic [3:0] s_sel;
  logic [15:0] e_cnt;

  logic [31:0] x_m_dat, x_s_adr, x_s_dat, x_e_adr;
  logic x_m_ack, x_m_err, x_s_we, x_irq;
  logic [N-1:0] x_s_cyc, x_s_stb;
  logic [3:0] x_s_sel;
  logic [15:0] x_e_cnt;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_decoder_n #(.NSLV(N), .BASE_ADDR(BASE), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .rst_i(rst), .m_cyc_i(cyc), .m_stb_i(stb),
    .m_we_i(we), .m_adr_i(adr), .m_dat_i(wdat), .m_sel_i(sel),
    .m_dat_o(m_dat), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_sel_o(s_sel),
    .s_dat_i(sdat), .s_ack_i(sack), .s_err_i(serr),
    .err_irq_o(irq), .err_cnt_o(e_cnt), .err_adr_o(e_adr)
  );

  wb_decoder_n #(.NSLV(N), .BASE_ADDR(BASE), .TIMEOUT_CYC(16),
                 .ERR_CNT_INIT(16'hFFFE)) dut_sat (
    .clk_i(clk), .rst_i(rst), .m_cyc_i(cyc), .m_stb_i(stb),
    .m_we_i(we), .m_adr_i(adr), .m_dat_i(wdat), .m_sel_i(sel),
    .m_dat_o(x_m_dat), .m_ack_o(x_m_ack), .m_err_o(x_m_err),
    .s_cyc_o(x_s_cyc), .s_stb_o(x_s_stb), .s_we_o(x_s_we),
    .s_adr_o(x_s_adr), .s_dat_o(x_s_dat), .s_sel_o(x_s_sel),
    .s_dat_i(sdat), .s_ack_i(sack), .s_err_i(serr),
    .err_irq_o(x_irq), .err_cnt_o(x_e_cnt), .err_adr_o(x_e_adr)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drop();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0;
    sack = '0; serr = '0; sdat = '0;
  endtask

  task automatic req(input logic w, input logic [31:0] a);
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; wdat = 32'h1234_5678; sel = 4'hF;
  endtask

  task automatic lo();
    @(negedge clk);
    #1;
  endtask

  initial begin
    drop();
    #2 rst = 1'b1;
    #1;
    chk("rst_outs", {m_ack, m_err, s_cyc, s_stb, irq, s_we}, '0);
    chk("rst_cnt", e_cnt, 16'h0);
    chk("rst_adr", e_adr, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: slave1 read, ack after 3 wait cycles
    @(negedge clk); req(1'b0, 32'h0200_1004); #1;
    chk("t1_idle_stb", s_stb, 4'b0000);
    lo();
    chk("t1_stb", s_stb, 4'b0010);
    chk("t1_cyc", s_cyc, 4'b0010);
    chk("t1_adr", s_adr, 32'h0200_1004);
    lo();
    chk("t1_nodat", {m_ack, m_dat}, '0);
    lo();
    @(negedge clk);
    sack = 4'b0010; sdat[63:32] = 32'hDEAD_BEEF; #1;
    chk("t1_ack", {m_ack, m_err}, 2'b10);
    chk("t1_dat", m_dat, 32'hDEAD_BEEF);
    @(negedge clk); drop(); #1;
    chk("t1_ack_off", {m_ack, m_dat}, '0);

    // 2: write to unmapped address
    @(negedge clk); req(1'b1, 32'hFFFF_0000); #1;
    chk("t2_lat", m_err, 1'b0);
    lo();
    chk("t2_err", {m_err, m_ack, s_stb, s_cyc}, {2'b10, 8'h00});
    @(negedge clk); drop(); #1;
    chk("t2_err_off", m_err, 1'b0);
    chk("t2_irq", irq, 1'b1);
    chk("t2_cnt", e_cnt, 16'd1);
    chk("t2_eadr", e_adr, 32'hFFFF_0000);
    chk("sat_a", x_e_cnt, 16'hFFFF);
    lo();
    chk("t2_irq_off", irq, 1'b0);

    // 3: slave3 never acks; stray acks/errs from others ignored
    @(negedge clk); req(1'b0, 32'h0300_0008);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      sack = (i == 5) ? 4'b0001 : 4'b0000;
      serr = (i == 5) ? 4'b0010 : 4'b0000;
      #1;
      if (i == 5) chk("t3_stray", {m_ack, m_err}, 2'b00);
      if (i == 15) chk("t3_c15", {m_err, s_stb}, 5'b0_1000);
    end
    @(negedge clk); sack = '0; serr = '0; #1;
    chk("t3_tmo", {m_err, m_ack, s_stb, s_cyc}, {2'b10, 8'h00});
    @(negedge clk); drop(); #1;
    chk("t3_irq", irq, 1'b1);
    chk("t3_cnt", e_cnt, 16'd2);
    chk("t3_eadr", e_adr, 32'h0300_0008);
    chk("sat_b", x_e_cnt, 16'hFFFF);

    // 4: overlap, slave0 wins; slave2 ack ignored
    @(negedge clk); req(1'b0, 32'h0100_0010);
    lo();
    chk("t4_stb", s_stb, 4'b0001);
    sack = 4'b0100; #1;
    chk("t4_ack2", m_ack, 1'b0);
    sack = 4'b0001; sdat[31:0] = 32'hA5A5_0001; #1;
    chk("t4_ack0", {m_ack, m_dat}, {1'b1, 32'hA5A5_0001});
    @(negedge clk); drop();

    // slave err has priority over ack
    @(negedge clk); req(1'b1, 32'h0200_1008);
    lo();
    sack = 4'b0010; serr = 4'b0010; #1;
    chk("t4_errpri", {m_err, m_ack, m_dat}, {2'b10, 32'h0});
    @(negedge clk); drop(); #1;
    chk("t4_cnt", e_cnt, 16'd3);

    // 5: abort in 2nd BUSY cycle
    @(negedge clk); req(1'b0, 32'h0200_1000);
    lo();
    chk("t5_cyc", s_cyc, 4'b0010);
    @(negedge clk); cyc = 1'b0; #1;
    chk("t5_abort", {s_cyc, s_stb, m_ack, m_err}, '0);
    @(negedge clk); drop(); #1;
    chk("t5_cnt", {irq, e_cnt}, {1'b0, 16'd3});

    // 6: async reset mid-BUSY
    @(negedge clk); req(1'b1, 32'h0200_1000);
    lo();
    chk("t6_busy", s_cyc, 4'b0010);
    #2 rst = 1'b1; #1;
    chk("t6_rst", {s_cyc, s_stb, s_we, m_ack, m_err}, '0);
    chk("t6_rst_adr", s_adr, 32'h0);
    chk("t6_rst_cnt", e_cnt, 16'h0);
    @(negedge clk); drop(); rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
